// File: rtl/simon_round_ctrl_pkg.sv
// simon_round_ctrl_pkg: shared SIMON mode encodings, word sizes, round counts and round helpers.
package simon_round_ctrl_pkg;

    localparam logic SIMON_MODE_64_128  = 1'b0;
    localparam logic SIMON_MODE_128_128 = 1'b1;

    localparam int SIMON_WORD_64_128  = 32;
    localparam int SIMON_WORD_128_128 = 64;

    localparam logic [6:0] SIMON_ROUNDS_64_128  = 7'd44;
    localparam logic [6:0] SIMON_ROUNDS_128_128 = 7'd68;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEY   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    function automatic logic [6:0] last_idx(input logic m);
        return (m == SIMON_MODE_128_128 ? SIMON_ROUNDS_128_128 : SIMON_ROUNDS_64_128) - 7'd1;
    endfunction

    function automatic logic [63:0] word_mask(input logic m);
        return m == SIMON_MODE_64_128 ? {{SIMON_WORD_64_128{1'b0}}, {SIMON_WORD_64_128{1'b1}}} : '1;
    endfunction

    // Left rotation within the active word size; 64/128 keeps the upper half zero.
    function automatic logic [63:0] rotl(input logic [63:0] x, input int s, input logic m);
        logic [31:0] h;
        h = x[31:0];
        return m == SIMON_MODE_64_128 ? {32'h0, (h << s) | (h >> (SIMON_WORD_64_128 - s))}
                                      : (x << s) | (x >> (SIMON_WORD_128_128 - s));
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] x, input logic m);
        return (rotl(x, 1, m) & rotl(x, 8, m)) ^ rotl(x, 2, m);
    endfunction

endpackage

// File: rtl/simon_round_ctrl_round.sv
// simon_round: one SIMON round per accepted i_valid, result visible two edges after acceptance.
module simon_round
    import simon_round_ctrl_pkg::*;
#(
    parameter int SIMON_MAX_WORD_WIDTH = 64
) (
    input  logic                            ck,
    input  logic                            nrst,
    input  logic                            i_valid,
    input  logic                            mode,
    input  logic                            enc_dec,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] key,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] block1_in,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] block2_in,
    output logic [SIMON_MAX_WORD_WIDTH-1:0] block1_out,
    output logic [SIMON_MAX_WORD_WIDTH-1:0] block2_out
);

    logic [SIMON_MAX_WORD_WIDTH-1:0] x_q, x_d, y_q, y_d, k_q, k_d, o1_q, o1_d, o2_q, o2_d;
    logic                            m_q, m_d, e_q, e_d, v_q, v_d;

    // Decrypt is the exact inverse round: (x, y) -> (y, x ^ f(y) ^ k).
    always_comb begin
        v_d  = i_valid;
        x_d  = i_valid ? block1_in : x_q;
        y_d  = i_valid ? block2_in : y_q;
        k_d  = i_valid ? key : k_q;
        m_d  = i_valid ? mode : m_q;
        e_d  = i_valid ? enc_dec : e_q;
        o1_d = v_q ? (e_q ? y_q ^ simon_f(x_q, m_q) ^ k_q : y_q) & word_mask(m_q) : o1_q;
        o2_d = v_q ? (e_q ? x_q : x_q ^ simon_f(y_q, m_q) ^ k_q) & word_mask(m_q) : o2_q;
    end

    always_ff @(posedge ck) begin
        if (!nrst) begin
            x_q  <= '0;
            y_q  <= '0;
            k_q  <= '0;
            m_q  <= 1'b0;
            e_q  <= 1'b0;
            v_q  <= 1'b0;
            o1_q <= '0;
            o2_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            k_q  <= k_d;
            m_q  <= m_d;
            e_q  <= e_d;
            v_q  <= v_d;
            o1_q <= o1_d;
            o2_q <= o2_d;
        end
    end

    assign block1_out = o1_q;
    assign block2_out = o2_q;

endmodule

// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: sequences T SIMON rounds through one round datapath, fetching a key per round.
module simon_round_ctrl
    import simon_round_ctrl_pkg::*;
#(
    parameter int SIMON_MAX_WORD_WIDTH = 64
) (
    input  logic                            ck,
    input  logic                            nrst,
    input  logic                            start,
    input  logic                            mode,
    input  logic                            enc_dec,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] block1_in,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] block2_in,
    output logic                            ready,
    output logic [6:0]                      rk_addr,
    input  logic [SIMON_MAX_WORD_WIDTH-1:0] rk_data,
    output logic [SIMON_MAX_WORD_WIDTH-1:0] block1_out,
    output logic [SIMON_MAX_WORD_WIDTH-1:0] block2_out,
    output logic                            done
);

    logic [2:0]                      state_q, state_d;
    logic [6:0]                      idx_q, idx_d, rk_addr_q, rk_addr_d, first_idx, end_idx;
    logic                            mode_q, mode_d, enc_q, enc_d, done_q, done_d;
    logic [SIMON_MAX_WORD_WIDTH-1:0] x_q, x_d, y_q, y_d, b1_q, b1_d, b2_q, b2_d, rnd_x, rnd_y;

    assign first_idx = enc_q ? '0 : last_idx(mode_q);
    assign end_idx   = enc_q ? last_idx(mode_q) : '0;

    // rk_addr is loaded on entry to KEY so the key store output is ready by ISSUE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rk_addr_d = rk_addr_q;
        mode_d    = mode_q;
        enc_d     = enc_q;
        x_d       = x_q;
        y_d       = y_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_KEY;
                mode_d    = mode;
                enc_d     = enc_dec;
                x_d       = block1_in;
                y_d       = block2_in;
                idx_d     = enc_dec ? '0 : last_idx(mode);
                rk_addr_d = idx_d;
            end
            ST_KEY:   state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: if (idx_q == end_idx) begin
                state_d = ST_FIN;
            end else begin
                state_d   = ST_KEY;
                idx_d     = enc_q ? idx_q + 7'd1 : idx_q - 7'd1;
                rk_addr_d = idx_d;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                b1_d    = rnd_x;
                b2_d    = rnd_y;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rk_addr_q <= '0;
            mode_q    <= 1'b0;
            enc_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rk_addr_q <= rk_addr_d;
            mode_q    <= mode_d;
            enc_q     <= enc_d;
            x_q       <= x_d;
            y_q       <= y_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            done_q    <= done_d;
        end
    end

    simon_round #(
        .SIMON_MAX_WORD_WIDTH(SIMON_MAX_WORD_WIDTH)
    ) u_round (
        .ck         (ck),
        .nrst       (nrst),
        .i_valid    (state_q == ST_ISSUE),
        .mode       (mode_q),
        .enc_dec    (enc_q),
        .key        (rk_data),
        .block1_in  (idx_q == first_idx ? x_q : rnd_x),
        .block2_in  (idx_q == first_idx ? y_q : rnd_y),
        .block1_out (rnd_x),
        .block2_out (rnd_y)
    );

    assign ready      = state_q == ST_IDLE;
    assign rk_addr    = rk_addr_q;
    assign block1_out = b1_q;
    assign block2_out = b2_q;
    assign done       = done_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// tb_simon_round_ctrl: directed checks of the SIMON round controller against published test vectors.
module tb_simon_round_ctrl;
    import simon_round_ctrl_pkg::*;

    logic        ck = 1'b0, nrst = 1'b1, start = 1'b0, mode = 1'b0, enc_dec = 1'b1;
    logic        ready, done, ks_sel = 1'b0;
    logic [6:0]  rk_addr;
    logic [63:0] block1_in = '0, block2_in = '0, rk_data = '0, block1_out, block2_out;
    logic [63:0] ks64 [0:127];
    logic [63:0] ks128 [0:127];
    logic [31:0] k32 [0:43];
    logic [63:0] k64 [0:67];
    int          total = 0, bad = 0, n;

    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [63:0] PT_X = 64'h656b696c, PT_Y = 64'h20646e75;
    localparam logic [63:0] CT_X = 64'h44c8fc20, CT_Y = 64'hb9dfa07a;

    simon_round_ctrl #(.SIMON_MAX_WORD_WIDTH(64)) dut (
        .ck(ck), .nrst(nrst), .start(start), .mode(mode), .enc_dec(enc_dec),
        .block1_in(block1_in), .block2_in(block2_in), .ready(ready), .rk_addr(rk_addr),
        .rk_data(rk_data), .block1_out(block1_out), .block2_out(block2_out), .done(done)
    );

    always #5 ck = ~ck;

    always @(posedge ck) rk_data <= ks_sel ? ks128[rk_addr] : ks64[rk_addr];

    function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
        return (v >> s) | (v << (32 - s));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick;
            cyc++;
        end while (!done && cyc < 400);
    endtask

    // kind 0: plain run; 1: extra start pulse at cycle hook; 2: reset asserted at cycle hook.
    task automatic run(input string tag, input logic m, input logic e, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] ex, input logic [63:0] ey,
                       input int kind, input int hook);
        int t, cyc, late;
        t = (m == SIMON_MODE_64_128) ? 44 : 68;
        mode = m;
        enc_dec = e;
        block1_in = x;
        block2_in = y;
        ks_sel = (m != SIMON_MODE_64_128);
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (kind == 1 && cyc == hook) begin
                start = 1'b1;
                chk({tag, " ready_busy"}, 64'(ready), 64'd0);
            end
            if (kind == 1 && cyc == hook + 1) start = 1'b0;
            if (!e && cyc % 3 == 1 && cyc <= 3 * t - 2)
                chk({tag, " rk_addr"}, 64'(rk_addr), 64'(t - 1 - (cyc - 1) / 3));
            if (kind == 2 && cyc == hook) begin
                nrst = 1'b0;
                #1;
                chk({tag, " rst_ready"}, 64'(ready), 64'd1);
                chk({tag, " rst_done"}, 64'(done), 64'd0);
                chk({tag, " rst_rk_addr"}, 64'(rk_addr), 64'd0);
                chk({tag, " rst_out1"}, block1_out, 64'd0);
                chk({tag, " rst_out2"}, block2_out, 64'd0);
                tick;
                tick;
                nrst = 1'b1;
                late = 0;
                repeat (150) begin
                    tick;
                    if (done) late++;
                end
                chk({tag, " no_done"}, 64'(late), 64'd0);
                chk({tag, " idle_ready"}, 64'(ready), 64'd1);
                return;
            end
            tick;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(3 * t + 2));
        chk({tag, " out1"}, block1_out, ex);
        chk({tag, " out2"}, block2_out, ey);
        chk({tag, " ready_done"}, 64'(ready), 64'd1);
        tick;
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        k32[0] = 32'h03020100;
        k32[1] = 32'h0b0a0908;
        k32[2] = 32'h13121110;
        k32[3] = 32'h1b1a1918;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] t;
            t = ror32(k32[i+3], 3) ^ k32[i+1];
            t = t ^ ror32(t, 1);
            k32[i+4] = ~k32[i] ^ t ^ {31'b0, Z3[61 - (i % 62)]} ^ 32'd3;
        end
        k64[0] = 64'h0706050403020100;
        k64[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 0; i < 66; i++) begin
            logic [63:0] t;
            t = ror64(k64[i+1], 3);
            t = t ^ ror64(t, 1);
            k64[i+2] = ~k64[i] ^ t ^ {63'b0, Z2[61 - (i % 62)]} ^ 64'd3;
        end
        for (int i = 0; i < 128; i++) begin
            ks64[i] = i < 44 ? {32'h0, k32[i]} : '0;
            ks128[i] = i < 68 ? k64[i] : '0;
        end

        #2 nrst = 1'b0;
        #1;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset done", 64'(done), 64'd0);
        chk("reset rk_addr", 64'(rk_addr), 64'd0);
        chk("reset out1", block1_out, 64'd0);
        chk("reset out2", block2_out, 64'd0);
        tick;
        tick;
        nrst = 1'b1;
        tick;

        run("enc64", SIMON_MODE_64_128, 1'b1, PT_X, PT_Y, CT_X, CT_Y, 0, 0);
        run("dec64", SIMON_MODE_64_128, 1'b0, CT_X, CT_Y, PT_X, PT_Y, 0, 0);
        run("enc128", SIMON_MODE_128_128, 1'b1, 64'h6373656420737265, 64'h6c6c657661727420,
            64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc, 0, 0);
        run("busy_start", SIMON_MODE_64_128, 1'b1, PT_X, PT_Y, CT_X, CT_Y, 1, 33);
        tick;
        chk("busy_start no_rerun", 64'(ready), 64'd1);
        run("rst_mid", SIMON_MODE_64_128, 1'b1, PT_X, PT_Y, CT_X, CT_Y, 2, 62);
        run("after_rst", SIMON_MODE_64_128, 1'b1, PT_X, PT_Y, CT_X, CT_Y, 0, 0);

        mode = SIMON_MODE_64_128;
        ks_sel = 1'b0;
        enc_dec = 1'b1;
        block1_in = PT_X;
        block2_in = PT_Y;
        start = 1'b1;
        wait_done(n);
        chk("b2b latency1", 64'(n), 64'd134);
        chk("b2b out1_a", block1_out, CT_X);
        chk("b2b out2_a", block2_out, CT_Y);
        enc_dec = 1'b0;
        block1_in = CT_X;
        block2_in = CT_Y;
        wait_done(n);
        start = 1'b0;
        chk("b2b gap", 64'(n), 64'd134);
        chk("b2b out1_b", block1_out, PT_X);
        chk("b2b out2_b", block2_out, PT_Y);
        tick;
        chk("b2b done_pulse", 64'(done), 64'd0);
        chk("b2b stopped", 64'(ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
